// File: rtl/control_unit_if.sv
//------------------------------------------------------------------------------
// control_unit_if : memory handshake, ALU flags and register-file controls
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface control_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        z_flag;
   logic        c_flag;
   logic [15:0] ir;
   logic [1:0]  in_sel;
   logic [2:0]  src_sel;
   logic [2:0]  dst_sel;
   logic        in_en;
   logic        up_en;
   logic        lo_en;
   logic        pc_inc;
   logic        sp_inc;
   logic        sp_dec;
   logic        jp_en;
   logic        br_en;
   logic [2:0]  alu_op;
   logic        flags_we;
   logic        halted;
   logic        illegal;

   modport master (
      input  mem_ack, mem_rdata, z_flag, c_flag,
      output mem_req, mem_we, ir, in_sel, src_sel, dst_sel,
             in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, jp_en, br_en,
             alu_op, flags_we, halted, illegal
   );

   modport slave (
      output mem_ack, mem_rdata, z_flag, c_flag,
      input  mem_req, mem_we, ir, in_sel, src_sel, dst_sel,
             in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, jp_en, br_en,
             alu_op, flags_we, halted, illegal
   );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// control_unit : tiny16 fetch/decode/execute sequencer driving regfile strobes
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_unit (
   input  logic           clk,
   input  logic           rst,
   control_unit_if.master bus
);

   localparam logic [3:0] c_OP_NOP  = 4'h0;
   localparam logic [3:0] c_OP_MOV  = 4'h1;
   localparam logic [3:0] c_OP_LDU  = 4'h2;
   localparam logic [3:0] c_OP_LDL  = 4'h3;
   localparam logic [3:0] c_OP_LD   = 4'h4;
   localparam logic [3:0] c_OP_ST   = 4'h5;
   localparam logic [3:0] c_OP_PUSH = 4'h6;
   localparam logic [3:0] c_OP_POP  = 4'h7;
   localparam logic [3:0] c_OP_JMP  = 4'h8;
   localparam logic [3:0] c_OP_BR   = 4'h9;
   localparam logic [3:0] c_OP_ALU  = 4'hA;
   localparam logic [3:0] c_OP_HLT  = 4'hF;

   localparam logic [2:0] c_REG_PC  = 3'd0;
   localparam logic [2:0] c_REG_SP  = 3'd1;

   localparam logic [1:0] c_IN_IR   = 2'd0;
   localparam logic [1:0] c_IN_MEM  = 2'd1;
   localparam logic [1:0] c_IN_ALU  = 2'd2;
   localparam logic [1:0] c_IN_SRC  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      r_state;
   logic [15:0] r_ir;

   // EXEC-phase Moore strobes, loaded on DECODE->EXEC and cleared the cycle after
   logic        r_in_en;
   logic        r_up_en;
   logic        r_lo_en;
   logic        r_sp_inc;
   logic        r_jp_en;
   logic        r_br_en;
   logic        r_flags_we;
   logic        r_illegal;

   logic [3:0]  w_op;
   logic [2:0]  w_rd;
   logic [2:0]  w_rs;
   logic        w_br_cond;
   logic        w_reserved;
   logic        w_mem_op;
   logic        w_mem_write;
   logic        w_mem_read_back;
   logic        w_in_decode;
   logic        w_fetch_done;
   logic        w_mem_done;
   logic [1:0]  w_in_sel;
   logic [2:0]  w_src_sel;
   logic [2:0]  w_dst_sel;

   assign w_op = r_ir[15:12];
   assign w_rd = r_ir[11:9];
   assign w_rs = r_ir[8:6];

   always_comb begin
      w_br_cond = 1'b0;
      case (r_ir[10:8])
         3'd0:    w_br_cond = 1'b1;
         3'd1:    w_br_cond = bus.z_flag;
         3'd2:    w_br_cond = ~bus.z_flag;
         3'd3:    w_br_cond = bus.c_flag;
         3'd4:    w_br_cond = ~bus.c_flag;
         default: w_br_cond = 1'b0;
      endcase
   end

   assign w_reserved      = (w_op >= 4'hB) && (w_op <= 4'hE);
   assign w_mem_write     = (w_op == c_OP_ST) || (w_op == c_OP_PUSH);
   assign w_mem_read_back = (w_op == c_OP_LD) || (w_op == c_OP_POP);
   assign w_mem_op        = w_mem_write || w_mem_read_back;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ir       <= 16'h0000;
         r_in_en    <= 1'b0;
         r_up_en    <= 1'b0;
         r_lo_en    <= 1'b0;
         r_sp_inc   <= 1'b0;
         r_jp_en    <= 1'b0;
         r_br_en    <= 1'b0;
         r_flags_we <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_in_en    <= 1'b0;
         r_up_en    <= 1'b0;
         r_lo_en    <= 1'b0;
         r_sp_inc   <= 1'b0;
         r_jp_en    <= 1'b0;
         r_br_en    <= 1'b0;
         r_flags_we <= 1'b0;
         r_illegal  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (bus.mem_ack) begin
                  r_ir    <= bus.mem_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
               case (w_op)
                  c_OP_MOV: r_in_en  <= 1'b1;
                  c_OP_LDU: r_up_en  <= 1'b1;
                  c_OP_LDL: r_lo_en  <= 1'b1;
                  c_OP_POP: r_sp_inc <= 1'b1;
                  c_OP_JMP: r_jp_en  <= 1'b1;
                  c_OP_BR:  r_br_en  <= w_br_cond;
                  c_OP_ALU: begin
                     r_in_en    <= 1'b1;
                     r_flags_we <= 1'b1;
                  end
                  default:  r_illegal <= w_reserved;
               endcase
            end
            S_EXEC: begin
               if (w_mem_op)
                  r_state <= S_MEM;
               else if (w_op == c_OP_HLT)
                  r_state <= S_HALT;
               else
                  r_state <= S_FETCH;
            end
            S_MEM: begin
               if (bus.mem_ack)
                  r_state <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_in_decode  = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM);
   assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ack;
   assign w_mem_done   = (r_state == S_MEM) && bus.mem_ack;

   // Selects depend only on ir and state, so they stay put while a request waits
   always_comb begin
      w_in_sel  = c_IN_IR;
      w_src_sel = c_REG_PC;
      w_dst_sel = c_REG_PC;
      if (w_in_decode) begin
         case (w_op)
            c_OP_MOV: begin
               w_in_sel  = c_IN_SRC;
               w_src_sel = w_rs;
               w_dst_sel = w_rd;
            end
            c_OP_LDU, c_OP_LDL: begin
               w_dst_sel = w_rd;
            end
            c_OP_LD: begin
               w_in_sel  = c_IN_MEM;
               w_src_sel = w_rs;
               w_dst_sel = w_rd;
            end
            c_OP_ST: begin
               w_src_sel = w_rs;
               w_dst_sel = w_rd;
            end
            c_OP_PUSH: begin
               w_src_sel = c_REG_SP;
               w_dst_sel = w_rd;
            end
            c_OP_POP: begin
               w_in_sel  = c_IN_MEM;
               w_src_sel = c_REG_SP;
               w_dst_sel = w_rd;
            end
            c_OP_ALU: begin
               w_in_sel  = c_IN_ALU;
               w_src_sel = w_rs;
               w_dst_sel = w_rd;
            end
            default: begin
               w_in_sel  = c_IN_IR;
               w_src_sel = c_REG_PC;
               w_dst_sel = c_REG_PC;
            end
         endcase
      end
   end

   assign bus.mem_req  = (r_state == S_FETCH) || (r_state == S_MEM);
   assign bus.mem_we   = (r_state == S_MEM) && w_mem_write;
   assign bus.ir       = r_ir;
   assign bus.in_sel   = w_in_sel;
   assign bus.src_sel  = w_src_sel;
   assign bus.dst_sel  = w_dst_sel;
   assign bus.in_en    = r_in_en || (w_mem_done && w_mem_read_back);
   assign bus.up_en    = r_up_en;
   assign bus.lo_en    = r_lo_en;
   assign bus.pc_inc   = w_fetch_done;
   assign bus.sp_inc   = r_sp_inc;
   assign bus.sp_dec   = w_mem_done && (w_op == c_OP_PUSH);
   assign bus.jp_en    = r_jp_en;
   assign bus.br_en    = r_br_en;
   assign bus.alu_op   = r_ir[2:0];
   assign bus.flags_we = r_flags_we;
   assign bus.halted   = (r_state == S_HALT);
   assign bus.illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// tb_control_unit : directed self-checking bench for control_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   control_unit_if bus();

   control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, jp_en, br_en}
   function automatic logic [7:0] strobes();
      return {bus.in_en, bus.up_en, bus.lo_en, bus.pc_inc,
              bus.sp_inc, bus.sp_dec, bus.jp_en, bus.br_en};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Enters in a FETCH cycle, acks with zero wait, returns in the DECODE cycle
   task automatic fetch(input logic [15:0] instr, input string tag);
      chk({tag, " fetch mem_req"}, 16'(bus.mem_req), 16'h1);
      chk({tag, " fetch src_sel"}, 16'(bus.src_sel), 16'h0);
      chk({tag, " fetch mem_we"},  16'(bus.mem_we),  16'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = instr;
      #1;
      chk({tag, " fetch pc_inc"}, 16'(strobes()), 16'h10);
      cyc();
      bus.mem_ack = 1'b0;
      #1;
      chk({tag, " decode ir"},      bus.ir, instr);
      chk({tag, " decode strobes"}, 16'(strobes()), 16'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int errs;
      rst           = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h0000;
      bus.z_flag    = 1'b0;
      bus.c_flag    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst mem_req",  16'(bus.mem_req),  16'h0);
      chk("rst strobes",  16'(strobes()),    16'h0);
      chk("rst ir",       bus.ir,            16'h0);
      chk("rst halted",   16'(bus.halted),   16'h0);
      chk("rst misc",     {bus.in_sel, bus.src_sel, bus.dst_sel, bus.alu_op,
                           bus.mem_we, bus.flags_we, bus.illegal}, 16'h0);

      rst = 1'b0;
      #1;
      chk("idle mem_req", 16'(bus.mem_req), 16'h0);
      chk("idle pc_inc",  16'(bus.pc_inc),  16'h0);
      bus.mem_ack = 1'b0;
      cyc();

      // NOP
      fetch(16'h0000, "nop");
      cyc();
      chk("nop exec strobes", 16'(strobes()), 16'h00);
      cyc();

      // LDL r2,0x34
      fetch(16'h3434, "ldl");
      cyc();
      chk("ldl exec strobes", 16'(strobes()),   16'h20);
      chk("ldl exec dst_sel", 16'(bus.dst_sel), 16'h2);
      chk("ldl exec in_sel",  16'(bus.in_sel),  16'h0);
      chk("ldl exec mem_req", 16'(bus.mem_req), 16'h0);
      cyc();
      chk("ldl refetch strobes", 16'(strobes()), 16'h00);

      // BR Z back 5, taken
      bus.z_flag = 1'b1;
      fetch(16'h9185, "br taken");
      cyc();
      chk("br taken exec strobes", 16'(strobes()),  16'h01);
      chk("br taken exec in_sel",  16'(bus.in_sel), 16'h0);
      cyc();

      // BR Z back 5, not taken
      bus.z_flag = 1'b0;
      fetch(16'h9185, "br not");
      cyc();
      chk("br not exec strobes", 16'(strobes()), 16'h00);
      cyc();

      // LD r3,[r4] with three wait cycles
      fetch(16'h4700, "ld");
      chk("ld decode src_sel", 16'(bus.src_sel), 16'h4);
      cyc();
      chk("ld exec strobes", 16'(strobes()),   16'h00);
      chk("ld exec mem_req", 16'(bus.mem_req), 16'h0);
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (bus.mem_req !== 1'b1 || bus.src_sel !== 3'd4 || bus.mem_we !== 1'b0 ||
             bus.dst_sel !== 3'd3 || strobes() !== 8'h00)
            errs++;
      end
      chk("ld wait cycles bad", 16'(errs), 16'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      #1;
      chk("ld ack strobes", 16'(strobes()),   16'h80);
      chk("ld ack in_sel",  16'(bus.in_sel),  16'h1);
      chk("ld ack dst_sel", 16'(bus.dst_sel), 16'h3);
      cyc();
      bus.mem_ack = 1'b0;
      #1;

      // PUSH r5 with one wait cycle
      fetch(16'h6A00, "push");
      cyc();
      chk("push exec strobes", 16'(strobes()), 16'h00);
      cyc();
      chk("push wait mem_req", 16'(bus.mem_req), 16'h1);
      chk("push wait mem_we",  16'(bus.mem_we),  16'h1);
      chk("push wait selects", {10'h0, bus.src_sel, bus.dst_sel}, 16'h000D);
      chk("push wait strobes", 16'(strobes()), 16'h00);
      bus.mem_ack = 1'b1;
      #1;
      chk("push ack strobes", 16'(strobes()), 16'h04);
      cyc();
      bus.mem_ack = 1'b0;
      #1;

      // POP r6, zero-wait
      fetch(16'h7C00, "pop");
      cyc();
      chk("pop exec strobes", 16'(strobes()),   16'h08);
      chk("pop exec mem_req", 16'(bus.mem_req), 16'h0);
      cyc();
      bus.mem_ack = 1'b1;
      #1;
      chk("pop ack mem_req", 16'(bus.mem_req), 16'h1);
      chk("pop ack mem_we",  16'(bus.mem_we),  16'h0);
      chk("pop ack selects", {10'h0, bus.src_sel, bus.dst_sel}, 16'h000E);
      chk("pop ack strobes", 16'(strobes()), 16'h80);
      cyc();
      bus.mem_ack = 1'b0;
      #1;

      // MOV r5,r1
      fetch(16'h1A40, "mov");
      cyc();
      chk("mov exec strobes", 16'(strobes()), 16'h80);
      chk("mov exec sel", {8'h0, bus.in_sel, bus.src_sel, bus.dst_sel}, 16'h00CD);
      cyc();

      // JMP forward 5
      fetch(16'h8805, "jmp");
      cyc();
      chk("jmp exec strobes", 16'(strobes()),  16'h02);
      chk("jmp exec in_sel",  16'(bus.in_sel), 16'h0);
      cyc();

      // ALU r1,r2 op 3
      fetch(16'hA283, "alu");
      cyc();
      chk("alu exec strobes",  16'(strobes()),    16'h80);
      chk("alu exec in_sel",   16'(bus.in_sel),   16'h2);
      chk("alu exec flags_we", 16'(bus.flags_we), 16'h1);
      chk("alu exec alu_op",   16'(bus.alu_op),   16'h3);
      cyc();
      chk("alu after flags_we", 16'(bus.flags_we), 16'h0);

      // Reserved opcode
      fetch(16'hB000, "resv");
      chk("resv decode illegal", 16'(bus.illegal), 16'h0);
      cyc();
      chk("resv exec illegal", 16'(bus.illegal), 16'h1);
      chk("resv exec strobes", 16'(strobes()),   16'h00);
      cyc();
      chk("resv refetch illegal", 16'(bus.illegal), 16'h0);
      chk("resv refetch mem_req", 16'(bus.mem_req), 16'h1);

      // HLT, then ignored acks while halted, then async reset
      fetch(16'hF000, "hlt");
      cyc();
      chk("hlt exec halted", 16'(bus.halted), 16'h0);
      cyc();
      chk("hlt halted", 16'(bus.halted), 16'h1);
      bus.mem_ack = 1'b1;
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (bus.mem_req !== 1'b0 || bus.halted !== 1'b1 || strobes() !== 8'h00)
            errs++;
      end
      chk("hlt hold bad cycles", 16'(errs), 16'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst halted",  16'(bus.halted),  16'h0);
      chk("async rst mem_req", 16'(bus.mem_req), 16'h0);
      bus.mem_ack = 1'b0;
      cyc();
      rst = 1'b0;
      #1;
      chk("restart idle mem_req", 16'(bus.mem_req), 16'h0);
      cyc();
      chk("restart fetch mem_req", 16'(bus.mem_req), 16'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
